multiplier_arbiter_tainttrack: RTL and testbench

//  Shares one sequential multiplier (control + datapath pair) between NREQ requesters.

---
 rtl/multiplier_arbiter_tainttrack_if.sv | 61 ++++++
 rtl/multiplier_arbiter_tainttrack.sv | 176 +++++++++++++++++
 tb/tb_multiplier_arbiter_tainttrack.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_arbiter_tainttrack_if.sv
// Bus bundle between the multiplier arbiter and its surroundings:
// requesters, the shared sequential multiplier and the response consumer.
// The slave modport is the arbiter's view.
// The master modport is the environment's view.
interface multiplier_arbiter_tainttrack_if #(
  parameter int WIDTH = 1024,
  parameter int NREQ  = 2
);
  localparam int IDW = $clog2(NREQ);

  // requester side
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_t;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ*WIDTH-1:0] op_a_t;
  logic [NREQ*WIDTH-1:0] op_b_t;
  logic [NREQ-1:0]       ack;

  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  rsp_t;
  logic [2*WIDTH-1:0]    rsp_data_t;

  // multiplier side
  logic                  mul_start;
  logic                  mul_start_t;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [WIDTH-1:0]      mul_a_t;
  logic [WIDTH-1:0]      mul_b_t;
  logic                  mul_done;
  logic                  mul_done_t;
  logic [2*WIDTH-1:0]    mul_product;
  logic [2*WIDTH-1:0]    mul_product_t;

  logic                  err;

  modport slave (
    input  req, req_t, op_a, op_b, op_a_t, op_b_t,
    output ack,
    output rsp_valid, rsp_id, rsp_data, rsp_t, rsp_data_t,
    input  rsp_ready,
    output mul_start, mul_start_t, mul_a, mul_b, mul_a_t, mul_b_t,
    input  mul_done, mul_done_t, mul_product, mul_product_t,
    output err
  );

  modport master (
    output req, req_t, op_a, op_b, op_a_t, op_b_t,
    input  ack,
    input  rsp_valid, rsp_id, rsp_data, rsp_t, rsp_data_t,
    output rsp_ready,
    input  mul_start, mul_start_t, mul_a, mul_b, mul_a_t, mul_b_t,
    output mul_done, mul_done_t, mul_product, mul_product_t,
    input  err
  );
endinterface

// File: rtl/multiplier_arbiter_tainttrack.sv
// Round-robin arbiter sharing one sequential multiplier between NREQ requesters.
// Shadow taint is carried through the arbitration decision, the operands and the result.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to enable the BUSY timeout.
// The timeout delivers a poisoned result and raises err.
module multiplier_arbiter_tainttrack #(
  parameter int WIDTH   = 1024,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  multiplier_arbiter_tainttrack_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic             state_t_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q, mul_a_t_q, mul_b_t_q;
  logic             mul_start_q, mul_start_t_q;
  logic             rsp_valid_q;
  logic [PW-1:0]    rsp_data_q, rsp_data_t_q;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q;
  logic             err_q;
`endif

  logic             grant_vld_d;
  logic [IDW-1:0]   grant_idx_d;
  logic [IDW-1:0]   rr_ptr_d;
  logic             req_t_any;
  logic [WIDTH-1:0] sel_a, sel_b, sel_a_t, sel_b_t;

  // Every request bit influences who wins, so the decision inherits all request taint.
  assign req_t_any = |bus.req_t;

  // Rotating-priority search: first set request at or above rr_ptr, wrapping around.
  always_comb begin
    int cand;
    cand        = 0;
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_vld_d && bus.req[cand]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = IDW'(cand);
      end
    end
    rr_ptr_d = IDW'((int'(grant_idx_d) + 1) % NREQ);
  end

  // Operand slices of the current winner.
  assign sel_a   = bus.op_a  [int'(grant_idx_d) * WIDTH +: WIDTH];
  assign sel_b   = bus.op_b  [int'(grant_idx_d) * WIDTH +: WIDTH];
  assign sel_a_t = bus.op_a_t[int'(grant_idx_d) * WIDTH +: WIDTH];
  assign sel_b_t = bus.op_b_t[int'(grant_idx_d) * WIDTH +: WIDTH];

  // ack is combinational from IDLE; it is forced low while rst is asserted.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ack
      assign bus.ack[gi] = !rst && (state_q == S_IDLE) && grant_vld_d &&
                           (grant_idx_d == IDW'(gi));
    end
  endgenerate

  // Arbitration / issue / wait / respond sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      state_t_q     <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_a_t_q     <= '0;
      mul_b_t_q     <= '0;
      mul_start_q   <= 1'b0;
      mul_start_t_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_data_t_q  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      mul_start_q   <= 1'b0;
      mul_start_t_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_t_q <= req_t_any;
          if (grant_vld_d) begin
            id_q          <= grant_idx_d;
            mul_a_q       <= sel_a;
            mul_b_q       <= sel_b;
            mul_a_t_q     <= sel_a_t;
            mul_b_t_q     <= sel_b_t;
            rr_ptr_q      <= rr_ptr_d;
            mul_start_q   <= 1'b1;
            mul_start_t_q <= req_t_any;
            state_q       <= S_ISSUE;
`ifdef MULT_ARB_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          state_q <= S_BUSY;
`ifdef MULT_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_BUSY: begin
          if (bus.mul_done) begin
            rsp_data_q   <= bus.mul_product;
            rsp_data_t_q <= bus.mul_product_t | {PW{state_t_q}};
            state_t_q    <= state_t_q | bus.mul_done_t;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Multiplier never answered: hand back a fully poisoned zero result.
            err_q        <= 1'b1;
            rsp_data_q   <= '0;
            rsp_data_t_q <= '1;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mul_start   = mul_start_q;
  assign bus.mul_start_t = mul_start_t_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.mul_a_t     = mul_a_t_q;
  assign bus.mul_b_t     = mul_b_t_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_data_t  = rsp_data_t_q;
  // Control taint is only meaningful while a response is presented.
  assign bus.rsp_t       = rsp_valid_q & state_t_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_arbiter_tainttrack.sv
// Bench for multiplier_arbiter_tainttrack: WIDTH=8, NREQ=2, TIMEOUT=16.
// The multiplier is modelled in the job task.
// Its product taint is {0, a_t | b_t} of the latched operands.
// Build with MULT_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_multiplier_arbiter_tainttrack;
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rr_model    = 0;

  always #5 clk = ~clk;

  multiplier_arbiter_tainttrack_if #(.WIDTH(W), .NREQ(N)) bus ();

  multiplier_arbiter_tainttrack #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One complete job: grant, issue, multiply, response hold, accept.
  task automatic run_job(input logic [N-1:0] rq, input logic [N-1:0] rqt,
                         input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic [N*W-1:0] at, input logic [N*W-1:0] bt,
                         input logic dt, input int delay, input int hold, input bit glitch);
    int g;
    logic [W-1:0]   aa, bb, aat, bbt;
    logic [2*W-1:0] prod, prod_t, exp_dt;
    logic [N-1:0]   exp_ack;
    logic           exp_t;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && rq[(rr_model + k) % N]) g = (rr_model + k) % N;
    aa = a[g*W +: W]; bb = b[g*W +: W]; aat = at[g*W +: W]; bbt = bt[g*W +: W];
    prod    = {{W{1'b0}}, aa} * {{W{1'b0}}, bb};
    prod_t  = {{W{1'b0}}, aat | bbt};
    exp_t   = (|rqt) | dt;
    exp_dt  = prod_t | {(2*W){|rqt}};
    exp_ack = '0;
    exp_ack[g] = 1'b1;

    @(negedge clk);
    bus.req = rq; bus.req_t = rqt; bus.op_a = a; bus.op_b = b;
    bus.op_a_t = at; bus.op_b_t = bt; bus.rsp_ready = 1'b0;
    #1;
    vectors++;
    if (bus.ack !== exp_ack) begin
      miscompares++; $display("FAIL ack: got %b expected %b", bus.ack, exp_ack);
    end

    @(negedge clk);
    if (glitch) begin
      bus.mul_done = 1'b1; bus.mul_product = '1; bus.mul_product_t = '1; bus.mul_done_t = 1'b1;
    end
    #1;
    vectors++;
    if ({bus.mul_start, bus.mul_start_t, bus.ack} !== {1'b1, |rqt, {N{1'b0}}}) begin
      miscompares++;
      $display("FAIL issue: got start=%b start_t=%b ack=%b expected 1 %b 0",
               bus.mul_start, bus.mul_start_t, bus.ack, |rqt);
    end
    vectors++;
    if ({bus.mul_a, bus.mul_b, bus.mul_a_t, bus.mul_b_t} !== {aa, bb, aat, bbt}) begin
      miscompares++;
      $display("FAIL operands: got %h %h %h %h expected %h %h %h %h",
               bus.mul_a, bus.mul_b, bus.mul_a_t, bus.mul_b_t, aa, bb, aat, bbt);
    end

    @(negedge clk);
    bus.mul_done = 1'b0; bus.mul_done_t = 1'b0;
    #1;
    vectors++;
    if ({bus.mul_start, bus.rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL busy: got start=%b valid=%b expected 0 0", bus.mul_start, bus.rsp_valid);
    end
    repeat (delay) begin
      @(negedge clk);
      bus.rsp_ready = 1'($urandom_range(0, 1));  // ignored outside RESP
    end
    bus.rsp_ready = 1'b0;
    bus.mul_done = 1'b1; bus.mul_product = prod; bus.mul_product_t = prod_t; bus.mul_done_t = dt;

    @(negedge clk);
    bus.mul_done = 1'b0; bus.mul_done_t = 1'b0;
    bus.mul_product = 16'($urandom); bus.mul_product_t = 16'($urandom);
    #1;
    vectors++;
    if ({bus.rsp_valid, 32'(bus.rsp_id), bus.err} !== {1'b1, 32'(g), 1'b0}) begin
      miscompares++;
      $display("FAIL rsp_ctrl: got valid=%b id=%0d err=%b expected 1 %0d 0",
               bus.rsp_valid, bus.rsp_id, bus.err, g);
    end
    vectors++;
    if ({bus.rsp_data, bus.rsp_data_t, bus.rsp_t} !== {prod, exp_dt, exp_t}) begin
      miscompares++;
      $display("FAIL rsp_data: got data=%h data_t=%h t=%b expected %h %h %b",
               bus.rsp_data, bus.rsp_data_t, bus.rsp_t, prod, exp_dt, exp_t);
    end
    repeat (hold) begin
      @(negedge clk); #1;
      vectors++;
      if ({bus.rsp_valid, bus.rsp_data, 32'(bus.rsp_id)} !== {1'b1, prod, 32'(g)}) begin
        miscompares++;
        $display("FAIL rsp_hold: got valid=%b data=%h id=%0d expected 1 %h %0d",
                 bus.rsp_valid, bus.rsp_data, bus.rsp_id, prod, g);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1; bus.req = '0; bus.req_t = '0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_t, bus.ack} !== {2'b00, {N{1'b0}}}) begin
      miscompares++;
      $display("FAIL accept: got valid=%b t=%b ack=%b expected 0 0 0",
               bus.rsp_valid, bus.rsp_t, bus.ack);
    end
    rr_model = (g + 1) % N;
  endtask

  task automatic test_reset();
    bus.req = 2'b11; bus.req_t = 2'b11;
    #3;
    vectors++;
    if ({bus.ack, bus.mul_start, bus.rsp_valid, bus.err} !== {{N{1'b0}}, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ack=%b start=%b valid=%b err=%b expected all 0",
               bus.ack, bus.mul_start, bus.rsp_valid, bus.err);
    end
    vectors++;
    if ({bus.rsp_data, bus.rsp_data_t, bus.rsp_t, bus.mul_start_t} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got data=%h data_t=%h t=%b start_t=%b expected 0",
               bus.rsp_data, bus.rsp_data_t, bus.rsp_t, bus.mul_start_t);
    end
    @(negedge clk);
    bus.req = '0; bus.req_t = '0;
    rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic test_round_robin();
    // Both request continuously: grants alternate 0,1,0; a long hold checks stability.
    run_job(2'b11, 2'b00, 16'h0503, 16'h0709, '0, '0, 1'b0, 1, 5, 1'b0);
    run_job(2'b11, 2'b00, 16'h0503, 16'h0709, '0, '0, 1'b0, 0, 5, 1'b0);
    run_job(2'b11, 2'b00, 16'h0503, 16'h0709, '0, '0, 1'b0, 2, 5, 1'b1);
  endtask

  task automatic test_basic();
    run_job(2'b01, 2'b00, 16'h0005, 16'h0007, '0, '0, 1'b0, 3, 0, 1'b0);
  endtask

  task automatic test_taint();
    run_job(2'b11, 2'b10, 16'h1234, 16'h5678, '0, '0, 1'b0, 1, 1, 1'b0);
    run_job(2'b01, 2'b00, 16'h00FF, 16'h00FF, '0, '0, 1'b0, 1, 1, 1'b0);
  endtask

  task automatic test_operand_taint();
    run_job(2'b01, 2'b00, 16'h000C, 16'h0011, 16'h0008, '0, 1'b0, 2, 0, 1'b0);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    bus.req = 2'b01; bus.op_a = 16'h0203; bus.op_b = 16'h0405;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);          // now in BUSY
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.ack, bus.mul_start, bus.rsp_valid, bus.err, bus.rsp_t, bus.mul_start_t} !== '0) begin
      miscompares++;
      $display("FAIL midop_rst_ctrl: got ack=%b start=%b valid=%b err=%b t=%b expected 0",
               bus.ack, bus.mul_start, bus.rsp_valid, bus.err, bus.rsp_t);
    end
    vectors++;
    if ({bus.rsp_data, bus.rsp_data_t, bus.mul_a, bus.mul_b} !== '0) begin
      miscompares++;
      $display("FAIL midop_rst_data: got data=%h data_t=%h a=%h b=%h expected 0",
               bus.rsp_data, bus.rsp_data_t, bus.mul_a, bus.mul_b);
    end
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
    run_job(2'b10, 2'b00, 16'h0B00, 16'h0D00, '0, '0, 1'b0, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [N-1:0]   rq, rqt;
      logic [N*W-1:0] at, bt;
      rq  = N'($urandom_range(1, 3));
      rqt = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      at  = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : '0;
      bt  = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : '0;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.req = '0; bus.req_t = N'($urandom);
        #1;
        vectors++;
        if (bus.ack !== '0) begin
          miscompares++; $display("FAIL idle_ack: got %b expected 00", bus.ack);
        end
      end
      run_job(rq, rqt, 16'($urandom), 16'($urandom), at, bt,
              1'($urandom_range(0, 7) == 0), $urandom_range(0, 4),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef MULT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    bus.req = 2'b01; bus.op_a = 16'h0009; bus.op_b = 16'h0009; bus.mul_done = 1'b0;
    @(negedge clk);          // ISSUE
    bus.req = '0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({bus.rsp_valid, bus.err} !== 2'b00) begin
        miscompares++;
        $display("FAIL timeout_early: cycle %0d got valid=%b err=%b expected 0 0",
                 i, bus.rsp_valid, bus.err);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if ({bus.err, bus.rsp_valid, bus.rsp_data, bus.rsp_data_t} !== {2'b11, 16'h0000, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL timeout: got err=%b valid=%b data=%h data_t=%h expected 1 1 0000 ffff",
               bus.err, bus.rsp_valid, bus.rsp_data, bus.rsp_data_t);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rr_model = 1;
    run_job(2'b01, 2'b00, 16'h0003, 16'h0004, '0, '0, 1'b0, 0, 0, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.req_t = '0; bus.op_a = '0; bus.op_b = '0;
    bus.op_a_t = '0; bus.op_b_t = '0; bus.rsp_ready = 1'b0;
    bus.mul_done = 1'b0; bus.mul_done_t = 1'b0;
    bus.mul_product = '0; bus.mul_product_t = '0;
    test_reset();
    test_round_robin();
    test_basic();
    test_taint();
    test_operand_taint();
    test_reset_midop();
    test_random();
`ifdef MULT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
